// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller (IDLE/FILL/WRITE FSM).
// Optional hit/miss statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpuReq,
    input  logic                     cpuWe,
    input  logic                     ByteOp,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     stall,
    output logic                     memReq,
    output logic                     memWe,
    output logic                     memByteOp,
    output logic [ADDRESS_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0]    memWData,
    input  logic                     memReady,
    input  logic [DATA_WIDTH-1:0]    memRData,
    output logic [31:0]              hitCount,
    output logic [31:0]              missCount
);

    localparam int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2;
    localparam int NUM_SETS  = 1 << SET_WIDTH;
    localparam int LANES     = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic                     byte_q, byte_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     hit_q, hit_d;
    logic                     wr_done_q, wr_done_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    logic [NUM_SETS-1:0]      valid_q;
    logic [TAG_WIDTH-1:0]     tag_mem  [NUM_SETS];
    logic [DATA_WIDTH-1:0]    data_mem [NUM_SETS];

    // Lookup side: decoded from the live CPU address.
    logic [SET_WIDTH-1:0]     cur_idx;
    logic [TAG_WIDTH-1:0]     cur_tag;
    logic [1:0]               cur_off;
    logic                     hit;
    logic [DATA_WIDTH-1:0]    lookup_word;
    logic [7:0]               rd_lane [LANES];
    logic [DATA_WIDTH-1:0]    load_val;
    logic                     load_hit;

    assign cur_off     = Address[1:0];
    assign cur_idx     = Address[SET_WIDTH+1:2];
    assign cur_tag     = Address[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign lookup_word = data_mem[cur_idx];
    assign hit         = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);

    // Update side: decoded from the latched transaction address.
    logic [SET_WIDTH-1:0]     upd_idx;
    logic [TAG_WIDTH-1:0]     upd_tag;
    logic [1:0]               upd_off;
    logic [DATA_WIDTH-1:0]    old_word;
    logic [DATA_WIDTH-1:0]    merged_word;
    logic                     fill_we;
    logic                     store_we;
    logic                     arr_we;
    logic [DATA_WIDTH-1:0]    arr_wdata;

    assign upd_off  = addr_q[1:0];
    assign upd_idx  = addr_q[SET_WIDTH+1:2];
    assign upd_tag  = addr_q[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign old_word = data_mem[upd_idx];

    // Big-endian lanes: lane 0 is the most significant byte of the word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign rd_lane[gi] = lookup_word[DATA_WIDTH-1-8*gi -: 8];
            assign merged_word[DATA_WIDTH-1-8*gi -: 8] =
                !byte_q                ? wdata_q[DATA_WIDTH-1-8*gi -: 8] :
                (upd_off == 2'(gi))    ? wdata_q[7:0] :
                                         old_word[DATA_WIDTH-1-8*gi -: 8];
        end
    endgenerate

    assign load_val = ByteOp ? {{(DATA_WIDTH-8){1'b0}}, rd_lane[cur_off]} : lookup_word;
    assign load_hit = (state_q == IDLE) && !wr_done_q && cpuReq && !cpuWe && hit;
    assign ReadData = load_hit ? load_val : rdata_q;
    assign rdata_d  = load_hit ? load_val : rdata_q;

    // Reset blocks array updates so an aborted transaction leaves no trace.
    assign fill_we   = !rst && (state_q == FILL) && memReady;
    assign store_we  = !rst && (state_q == WRITE) && memReady && hit_q && valid_q[upd_idx];
    assign arr_we    = fill_we || store_we;
    assign arr_wdata = fill_we ? memRData : merged_word;
    assign memWData  = wdata_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        byte_d    = byte_q;
        wdata_d   = wdata_q;
        hit_d     = hit_q;
        wr_done_d = 1'b0;
        stall     = 1'b0;
        memReq    = 1'b0;
        memWe     = 1'b0;
        memByteOp = 1'b0;
        memAddr   = addr_q;
        unique case (state_q)
            IDLE: begin
                // The cycle right after a write completes lets the held store retire.
                if (cpuReq && !wr_done_q) begin
                    if (cpuWe) begin
                        stall   = 1'b1;
                        addr_d  = Address;
                        byte_d  = ByteOp;
                        wdata_d = WriteData;
                        hit_d   = hit;
                        state_d = WRITE;
                    end else if (!hit) begin
                        stall   = 1'b1;
                        addr_d  = Address;
                        byte_d  = ByteOp;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall   = 1'b1;
                memReq  = 1'b1;
                memAddr = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
                if (memReady) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                stall     = 1'b1;
                memReq    = 1'b1;
                memWe     = 1'b1;
                memByteOp = byte_q;
                memAddr   = addr_q;
                if (memReady) begin
                    state_d   = IDLE;
                    wr_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            byte_q    <= 1'b0;
            wdata_q   <= '0;
            hit_q     <= 1'b0;
            wr_done_q <= 1'b0;
            rdata_q   <= '0;
            valid_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            byte_q    <= byte_d;
            wdata_q   <= wdata_d;
            hit_q     <= hit_d;
            wr_done_q <= wr_done_d;
            rdata_q   <= rdata_d;
            if (fill_we) begin
                valid_q[upd_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_mem[upd_idx] <= arr_wdata;
        end
        if (fill_we) begin
            tag_mem[upd_idx] <= upd_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (load_hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == FILL)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table, expected-read scoreboard and a latency-programmable memory model.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuReq;
    logic        cpuWe;
    logic        ByteOp;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic        memByteOp;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic        memReady = 1'b0;
    logic [31:0] memRData = 32'h0;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpuReq    (cpuReq),
        .cpuWe     (cpuWe),
        .ByteOp    (ByteOp),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .stall     (stall),
        .memReq    (memReq),
        .memWe     (memWe),
        .memByteOp (memByteOp),
        .memAddr   (memAddr),
        .memWData  (memWData),
        .memReady  (memReady),
        .memRData  (memRData),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    typedef struct {
        logic        we;
        logic        bop;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rd;
        int          exp_stall;
        int          exp_req;
        logic [31:0] exp_maddr;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          lat = 1;
    int          rsp_cnt = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_q [$];
    vec_t        vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: completes a request on its lat-th cycle of memReq.
    always @(negedge clk) begin
        logic [31:0] key;
        logic [31:0] w;
        memReady = 1'b0;
        if (memReq) begin
            rsp_cnt++;
            if (rsp_cnt >= lat) begin
                rsp_cnt  = 0;
                memReady = 1'b1;
                key = {memAddr[31:2], 2'b00};
                w = mem_model.exists(key) ? mem_model[key] : 32'h0;
                if (memWe) begin
                    if (memByteOp) begin
                        case (memAddr[1:0])
                            2'd0: w[31:24] = memWData[7:0];
                            2'd1: w[23:16] = memWData[7:0];
                            2'd2: w[15:8]  = memWData[7:0];
                            default: w[7:0] = memWData[7:0];
                        endcase
                    end else begin
                        w = memWData;
                    end
                    mem_model[key] = w;
                end
                memRData = w;
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    task automatic run_vec(input int n, input vec_t v);
        int          stall_n = 0;
        int          req_n = 0;
        bit          done = 0;
        logic [31:0] first_addr = 32'h0;
        logic [31:0] first_wd = 32'h0;
        logic        first_we = 1'b0;
        logic        first_bop = 1'b0;
        logic [31:0] exp_rd;
        @(negedge clk);
        lat       = v.lat;
        cpuReq    = 1'b1;
        cpuWe     = v.we;
        ByteOp    = v.bop;
        Address   = v.addr;
        WriteData = v.wdata;
        if (!v.we) begin
            exp_q.push_back(v.exp_rd);
            if (v.exp_stall == 0) begin
                exp_hits++;
            end else begin
                exp_misses++;
                exp_hits++;
            end
        end
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            #1;
            if (memReq) begin
                if (req_n == 0) begin
                    first_addr = memAddr;
                    first_we   = memWe;
                    first_bop  = memByteOp;
                    first_wd   = memWData;
                end
                req_n++;
            end
            if (stall) stall_n++;
            else done = 1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn%0d_timeout: stall still high after 40 cycles, required release", n);
        end else begin
            check($sformatf("txn%0d_memreq_gap", n), {31'b0, memReq}, 32'h0);
        end
        if (!v.we) begin
            exp_rd = exp_q.pop_front();
            check($sformatf("txn%0d_rdata", n), ReadData, exp_rd);
        end
        check($sformatf("txn%0d_stall_cycles", n), 32'(stall_n), 32'(v.exp_stall));
        check($sformatf("txn%0d_memreq_cycles", n), 32'(req_n), 32'(v.exp_req));
        if (v.exp_req > 0) begin
            check($sformatf("txn%0d_memaddr", n), first_addr, v.exp_maddr);
            check($sformatf("txn%0d_memwe", n), {31'b0, first_we}, {31'b0, v.we});
            check($sformatf("txn%0d_membyteop", n), {31'b0, first_bop}, {31'b0, v.we & v.bop});
            if (v.we) begin
                check($sformatf("txn%0d_memwdata", n), first_wd, v.wdata);
            end
        end
        $display("txn %0d we=%0b byte=%0b addr=%h rdata=%h stall_cycles=%0d mem_cycles=%0d",
                 n, v.we, v.bop, v.addr, ReadData, stall_n, req_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_h;
        logic [31:0] exp_m;
        vec_t        rv;

        rst = 1'b1; cpuReq = 1'b0; cpuWe = 1'b0; ByteOp = 1'b0;
        Address = 32'h0; WriteData = 32'h0;
        mem_model[32'h0001_0000] = 32'hDEAD_BEEF;
        mem_model[32'h0001_03FC] = 32'h0BAD_F00D;
        mem_model[32'h0002_0000] = 32'h1122_3344;
        mem_model[32'h0003_0000] = 32'h7766_5544;

        //            we    bop   addr          wdata         lat exp_rd        stl req maddr
        vecs[0]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,        3, 32'hDEAD_BEEF, 4, 3, 32'h0001_0000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,        3, 32'hDEAD_BEEF, 0, 0, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0001_0002, 32'h0,        3, 32'h0000_00BE, 0, 0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0001_0001, 32'hAABB_CC55, 2, 32'h0,        3, 2, 32'h0001_0001};
        vecs[4]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,        2, 32'hDE55_BEEF, 0, 0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0001_0400, 32'h1234_5678, 1, 32'h0,        2, 1, 32'h0001_0400};
        vecs[6]  = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,        1, 32'hDE55_BEEF, 0, 0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0001_0400, 32'h0,        2, 32'h1234_5678, 3, 2, 32'h0001_0400};
        vecs[8]  = '{1'b0, 1'b1, 32'h0001_0403, 32'h0,        2, 32'h0000_0078, 0, 0, 32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0001_03FC, 32'h0,        1, 32'h0BAD_F00D, 2, 1, 32'h0001_03FC};
        vecs[10] = '{1'b0, 1'b0, 32'h0001_0400, 32'h0,        1, 32'h1234_5678, 0, 0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0001_03FC, 32'h0,        1, 32'h0000_000B, 0, 0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 32'h0001_03FC, 32'hCAFE_F00D, 2, 32'h0,        3, 2, 32'h0001_03FC};
        vecs[13] = '{1'b0, 1'b0, 32'h0001_03FC, 32'h0,        2, 32'hCAFE_F00D, 0, 0, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 32'h0002_0003, 32'h0,        4, 32'h0000_0044, 5, 4, 32'h0002_0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_memreq", {31'b0, memReq}, 32'h0);
        check("rst_memwe", {31'b0, memWe}, 32'h0);
        check("rst_rdata", ReadData, 32'h0);
        check("rst_hitcount", hitCount, 32'h0);
        check("rst_misscount", missCount, 32'h0);

        for (int i = 0; i < 15; i++) begin
            run_vec(i, vecs[i]);
        end

        @(negedge clk);
        cpuReq = 1'b0;
        @(negedge clk);
        #1;
`ifdef DCACHE_STATS_EN
        exp_h = 32'(exp_hits);
        exp_m = 32'(exp_misses);
`else
        exp_h = 32'h0;
        exp_m = 32'h0;
`endif
        check("table_hitcount", hitCount, exp_h);
        check("table_misscount", missCount, exp_m);

        // Reset in the FILL cycle where memReady is high must abort the fill.
        @(negedge clk);
        lat = 3; cpuReq = 1'b1; cpuWe = 1'b0; ByteOp = 1'b0; Address = 32'h0003_0000;
        #1;
        check("abort_detect_stall", {31'b0, stall}, 32'h1);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("abort_fill_memreq", {31'b0, memReq}, 32'h1);
        end
        @(negedge clk);
        rst = 1'b1; cpuReq = 1'b0;
        #1;
        check("abort_ready_in_rst_cycle", {31'b0, memReady}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_memreq", {31'b0, memReq}, 32'h0);
        check("abort_stall", {31'b0, stall}, 32'h0);
        check("abort_rdata", ReadData, 32'h0);
        check("abort_hitcount", hitCount, 32'h0);
        check("abort_misscount", missCount, 32'h0);
        exp_hits = 0;
        exp_misses = 0;

        rv = '{1'b0, 1'b0, 32'h0003_0000, 32'h0, 2, 32'h7766_5544, 3, 2, 32'h0003_0000};
        run_vec(15, rv);

        @(negedge clk);
        cpuReq = 1'b0;
        @(negedge clk);
        #1;
`ifdef DCACHE_STATS_EN
        exp_h = 32'(exp_hits);
        exp_m = 32'(exp_misses);
`else
        exp_h = 32'h0;
        exp_m = 32'h0;
`endif
        check("final_hitcount", hitCount, exp_h);
        check("final_misscount", missCount, exp_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
